// File: rtl/semaforo_monitor_if.sv
// Lamp inputs and decoded monitor results for semaforo_monitor.
// master = lamp driver / result consumer, slave = the monitor itself.
interface semaforo_monitor_if #(
  parameter int CNT_W = 6
);
  logic             red;
  logic             yellow;
  logic             green;
  logic [2:0]       phase;
  logic [CNT_W-1:0] dur;
  logic             go;
  logic             preempt;
  logic             fault;
  logic [2:0]       fault_code;
  logic [7:0]       cycles;

  modport master (
    output red, yellow, green,
    input  phase, dur, go, preempt, fault, fault_code, cycles
  );

  modport slave (
    input  red, yellow, green,
    output phase, dur, go, preempt, fault, fault_code, cycles
  );
endinterface

// File: rtl/semaforo_monitor.sv
// Traffic-light lamp observer: decodes phase, times each colour, separates
// stop-override preemption from violations, counts full cycles.
module semaforo_monitor #(
  parameter int RED_LEN    = 10,
  parameter int YELLOW_LEN = 3,
  parameter int GREEN_LEN  = 20,
  parameter int CNT_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  semaforo_monitor_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_DARK_INIT = 3'd0,
    ST_RED       = 3'd1,
    ST_YELLOW    = 3'd2,
    ST_GREEN     = 3'd3,
    ST_PRE_Y     = 3'd4,
    ST_PRE_G     = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    FC_NONE  = 3'd0,
    FC_MULTI = 3'd1,
    FC_DARK  = 3'd2,
    FC_ORDER = 3'd3,
    FC_SHORT = 3'd4,
    FC_LONG  = 3'd5
  } fcode_t;

  localparam logic [CNT_W-1:0] L_RED    = CNT_W'(RED_LEN);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(YELLOW_LEN);
  localparam logic [CNT_W-1:0] L_GREEN  = CNT_W'(GREEN_LEN);
  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  fcode_t           r_code, w_code_nxt;
  logic [CNT_W-1:0] r_dur, w_dur_nxt;
  logic [7:0]       r_cycles, w_cycles_nxt;

  logic             w_multi;
  logic             w_dark;
  logic [CNT_W-1:0] w_dur_inc;

  assign w_multi   = (bus.red & bus.yellow) | (bus.red & bus.green) | (bus.yellow & bus.green);
  assign w_dark    = ~(bus.red | bus.yellow | bus.green);
  assign w_dur_inc = r_dur + L_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_DARK_INIT;
      r_code   <= FC_NONE;
      r_dur    <= '0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_dur    <= w_dur_nxt;
      r_cycles <= w_cycles_nxt;
    end
  end

  // Violations only touch state and code, so dur/cycles freeze at their last value.
  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_dur_nxt    = r_dur;
    w_cycles_nxt = r_cycles;
    if (r_state != ST_FAULT && w_multi) begin
      w_state_nxt = ST_FAULT;
      w_code_nxt  = FC_MULTI;
    end else if (r_state != ST_FAULT && w_dark && r_state != ST_DARK_INIT) begin
      w_state_nxt = ST_FAULT;
      w_code_nxt  = FC_DARK;
    end else begin
      case (r_state)
        ST_DARK_INIT: begin
          if (bus.red) begin
            w_state_nxt = ST_RED;
            w_dur_nxt   = L_ONE;
          end else if (bus.yellow || bus.green) begin
            w_state_nxt = ST_FAULT;
            w_code_nxt  = FC_ORDER;
          end
        end
        ST_RED: begin
          if (bus.red) begin
            w_dur_nxt = (r_dur == '1) ? r_dur : w_dur_inc;
          end else if (bus.yellow) begin
            if (r_dur >= L_RED) begin
              w_state_nxt = ST_YELLOW;
              w_dur_nxt   = L_ONE;
            end else begin
              w_state_nxt = ST_FAULT;
              w_code_nxt  = FC_SHORT;
            end
          end else begin
            w_state_nxt = ST_FAULT;
            w_code_nxt  = FC_ORDER;
          end
        end
        ST_YELLOW, ST_PRE_Y: begin
          if (bus.red) begin
            w_state_nxt = ST_PRE_Y;
          end else if (bus.yellow) begin
            if (r_dur == L_YELLOW) begin
              w_state_nxt = ST_FAULT;
              w_code_nxt  = FC_LONG;
            end else begin
              w_state_nxt = ST_YELLOW;
              w_dur_nxt   = w_dur_inc;
            end
          end else if (r_state == ST_YELLOW && r_dur == L_YELLOW) begin
            w_state_nxt = ST_GREEN;
            w_dur_nxt   = L_ONE;
          end else begin
            w_state_nxt = ST_FAULT;
            w_code_nxt  = (r_state == ST_YELLOW) ? FC_SHORT : FC_ORDER;
          end
        end
        ST_GREEN, ST_PRE_G: begin
          if (bus.red) begin
            if (r_state == ST_GREEN && r_dur == L_GREEN) begin
              w_state_nxt  = ST_RED;
              w_dur_nxt    = L_ONE;
              w_cycles_nxt = r_cycles + 8'd1;
            end else begin
              w_state_nxt = ST_PRE_G;
            end
          end else if (bus.green) begin
            if (r_dur == L_GREEN) begin
              w_state_nxt = ST_FAULT;
              w_code_nxt  = FC_LONG;
            end else begin
              w_state_nxt = ST_GREEN;
              w_dur_nxt   = w_dur_inc;
            end
          end else begin
            w_state_nxt = ST_FAULT;
            w_code_nxt  = FC_ORDER;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.phase      = r_state;
  assign bus.dur        = r_dur;
  assign bus.go         = (r_state == ST_GREEN);
  assign bus.preempt    = (r_state == ST_PRE_Y) || (r_state == ST_PRE_G);
  assign bus.fault      = (r_state == ST_FAULT);
  assign bus.fault_code = r_code;
  assign bus.cycles     = r_cycles;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed scenarios plus random lamp sequences checked against a
// colour-timing reference model.
module tb_semaforo_monitor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   go_cnt = 0;
  int   pre_cnt = 0;

  // reference model: 0 dark-init,1 red,2 yellow,3 green,4 red-over-yellow,5 red-over-green,6 fault
  int m_phase, m_dur, m_cycles, m_code;

  semaforo_monitor_if #(.CNT_W(6)) bus ();

  semaforo_monitor #(
    .RED_LEN(10), .YELLOW_LEN(3), .GREEN_LEN(20), .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic m_fail(input int code);
    m_phase = 6;
    m_code  = code;
  endtask

  task automatic model_step(input bit r, input bit y, input bit g);
    int lit;
    lit = int'(r) + int'(y) + int'(g);
    if (m_phase == 6) return;
    if (lit > 1) begin m_fail(1); return; end
    if (lit == 0) begin if (m_phase != 0) m_fail(2); return; end
    if (m_phase == 0) begin
      if (r) begin m_phase = 1; m_dur = 1; end else m_fail(3);
    end else if (m_phase == 1) begin
      if (r) m_dur = (m_dur < 63) ? m_dur + 1 : 63;
      else if (y && m_dur >= 10) begin m_phase = 2; m_dur = 1; end
      else if (y) m_fail(4);
      else m_fail(3);
    end else if (m_phase == 2 || m_phase == 4) begin
      if (r) m_phase = 4;
      else if (y && m_dur == 3) m_fail(5);
      else if (y) begin m_phase = 2; m_dur++; end
      else if (m_phase == 2 && m_dur == 3) begin m_phase = 3; m_dur = 1; end
      else m_fail(m_phase == 2 ? 4 : 3);
    end else begin
      if (r && m_phase == 3 && m_dur == 20) begin
        m_phase = 1; m_dur = 1; m_cycles = (m_cycles + 1) % 256;
      end else if (r) m_phase = 5;
      else if (g && m_dur == 20) m_fail(5);
      else if (g) begin m_phase = 3; m_dur++; end
      else m_fail(3);
    end
  endtask

  task automatic send(input bit r, input bit y, input bit g, input int n);
    for (int k = 0; k < n; k++) begin
      bus.red = r; bus.yellow = y; bus.green = g;
      @(posedge clk); #1;
      model_step(r, y, g);
      if (bus.go) go_cnt++;
      if (bus.preempt) pre_cnt++;
    end
  endtask

  task automatic do_reset();
    bus.red = 1'b0; bus.yellow = 1'b0; bus.green = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_phase = 0; m_dur = 0; m_cycles = 0; m_code = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if ({bus.phase, bus.dur, bus.go, bus.preempt, bus.fault, bus.fault_code, bus.cycles} !== '0)
      $display("FAIL reset_outputs: got phase=%0d dur=%0d go=%0d pre=%0d flt=%0d code=%0d cyc=%0d, required all 0",
               bus.phase, bus.dur, bus.go, bus.preempt, bus.fault, bus.fault_code, bus.cycles); else n_pass++;
  endtask

  task automatic test_full_cycle();
    do_reset();
    send(1, 0, 0, 10);
    n_chk++; if (bus.phase !== 3'd1 || bus.dur !== 6'd10) $display("FAIL t1_red: got phase=%0d dur=%0d, required 1/10", bus.phase, bus.dur); else n_pass++;
    send(0, 1, 0, 3);
    n_chk++; if (bus.phase !== 3'd2 || bus.dur !== 6'd3) $display("FAIL t1_yellow: got phase=%0d dur=%0d, required 2/3", bus.phase, bus.dur); else n_pass++;
    go_cnt = 0;
    send(0, 0, 1, 20);
    n_chk++; if (bus.phase !== 3'd3 || bus.dur !== 6'd20) $display("FAIL t1_green: got phase=%0d dur=%0d, required 3/20", bus.phase, bus.dur); else n_pass++;
    send(1, 0, 0, 1);
    n_chk++; if (bus.phase !== 3'd1 || bus.cycles !== 8'd1 || bus.fault !== 1'b0)
      $display("FAIL t1_complete: got phase=%0d cycles=%0d fault=%0d, required 1/1/0", bus.phase, bus.cycles, bus.fault); else n_pass++;
    n_chk++; if (go_cnt != 20) $display("FAIL t1_go_len: got %0d, required 20", go_cnt); else n_pass++;
  endtask

  task automatic test_preempt_yellow();
    do_reset();
    send(1, 0, 0, 10); send(0, 1, 0, 1);
    pre_cnt = 0;
    send(1, 0, 0, 5);
    n_chk++; if (bus.phase !== 3'd4 || bus.dur !== 6'd1) $display("FAIL t2_pre_y: got phase=%0d dur=%0d, required 4/1", bus.phase, bus.dur); else n_pass++;
    send(0, 1, 0, 2);
    n_chk++; if (bus.phase !== 3'd2 || bus.dur !== 6'd3) $display("FAIL t2_resume: got phase=%0d dur=%0d, required 2/3", bus.phase, bus.dur); else n_pass++;
    send(0, 0, 1, 20); send(1, 0, 0, 1);
    n_chk++; if (pre_cnt != 5) $display("FAIL t2_pre_len: got %0d, required 5", pre_cnt); else n_pass++;
    n_chk++; if (bus.phase !== 3'd1 || bus.cycles !== 8'd1 || bus.fault !== 1'b0)
      $display("FAIL t2_complete: got phase=%0d cycles=%0d fault=%0d, required 1/1/0", bus.phase, bus.cycles, bus.fault); else n_pass++;
  endtask

  task automatic test_preempt_green_short();
    do_reset();
    send(1, 0, 0, 10); send(0, 1, 0, 3); send(0, 0, 1, 7); send(1, 0, 0, 4);
    n_chk++; if (bus.phase !== 3'd5 || bus.dur !== 6'd7 || bus.go !== 1'b0)
      $display("FAIL t3_pre_g: got phase=%0d dur=%0d go=%0d, required 5/7/0", bus.phase, bus.dur, bus.go); else n_pass++;
    send(0, 0, 1, 13); send(1, 0, 0, 1);
    n_chk++; if (bus.phase !== 3'd1 || bus.cycles !== 8'd1) $display("FAIL t3_complete: got phase=%0d cycles=%0d, required 1/1", bus.phase, bus.cycles); else n_pass++;
    do_reset();
    send(1, 0, 0, 9); send(0, 1, 0, 1);
    n_chk++; if (bus.fault !== 1'b1 || bus.fault_code !== 3'd4) $display("FAIL t3_short: got fault=%0d code=%0d, required 1/4", bus.fault, bus.fault_code); else n_pass++;
    send(1, 0, 0, 10); send(0, 1, 0, 3);
    n_chk++; if (bus.phase !== 3'd6 || bus.fault_code !== 3'd4 || bus.dur !== 6'd9)
      $display("FAIL t3_sticky: got phase=%0d code=%0d dur=%0d, required 6/4/9", bus.phase, bus.fault_code, bus.dur); else n_pass++;
    do_reset();
    send(1, 0, 0, 70);
    n_chk++; if (bus.dur !== 6'd63 || bus.phase !== 3'd1) $display("FAIL t3_saturate: got dur=%0d phase=%0d, required 63/1", bus.dur, bus.phase); else n_pass++;
  endtask

  task automatic test_multi_dark();
    do_reset();
    send(1, 0, 0, 10); send(1, 0, 1, 1);
    n_chk++; if (bus.fault_code !== 3'd1 || bus.go !== 1'b0 || bus.phase !== 3'd6)
      $display("FAIL t4_multi: got code=%0d go=%0d phase=%0d, required 1/0/6", bus.fault_code, bus.go, bus.phase); else n_pass++;
    do_reset();
    send(0, 0, 0, 4);
    n_chk++; if (bus.phase !== 3'd0 || bus.fault !== 1'b0) $display("FAIL t4_init_dark: got phase=%0d fault=%0d, required 0/0", bus.phase, bus.fault); else n_pass++;
    send(1, 0, 0, 3); send(0, 0, 0, 1);
    n_chk++; if (bus.fault_code !== 3'd2 || bus.fault !== 1'b1) $display("FAIL t4_dark: got code=%0d fault=%0d, required 2/1", bus.fault_code, bus.fault); else n_pass++;
  endtask

  task automatic test_long_order();
    do_reset();
    send(1, 0, 0, 10); send(0, 1, 0, 3); send(0, 0, 1, 20); send(1, 0, 0, 10); send(0, 1, 0, 3); send(0, 0, 1, 20);
    n_chk++; if (bus.go !== 1'b1 || bus.cycles !== 8'd1) $display("FAIL t5_go_before: got go=%0d cycles=%0d, required 1/1", bus.go, bus.cycles); else n_pass++;
    send(0, 0, 1, 1);
    n_chk++; if (bus.fault_code !== 3'd5 || bus.go !== 1'b0 || bus.dur !== 6'd20)
      $display("FAIL t5_long: got code=%0d go=%0d dur=%0d, required 5/0/20", bus.fault_code, bus.go, bus.dur); else n_pass++;
    do_reset();
    send(0, 1, 0, 4); send(0, 1, 0, 0);
    send(1, 0, 0, 0);
    do_reset();
    send(1, 0, 0, 1); send(0, 0, 1, 1);
    n_chk++; if (bus.fault_code !== 3'd3 || bus.phase !== 3'd6) $display("FAIL t5_order: got code=%0d phase=%0d, required 3/6", bus.fault_code, bus.phase); else n_pass++;
  endtask

  task automatic test_reset_midrun_wrap();
    do_reset();
    send(1, 0, 0, 10); send(0, 1, 0, 3); send(0, 0, 1, 5);
    do_reset();
    n_chk++; if ({bus.phase, bus.dur, bus.go, bus.preempt, bus.fault, bus.fault_code, bus.cycles} !== '0)
      $display("FAIL t6_rst_green: got phase=%0d dur=%0d go=%0d, required all 0", bus.phase, bus.dur, bus.go); else n_pass++;
    send(1, 0, 0, 10); send(0, 1, 0, 3);
    n_chk++; if (bus.phase !== 3'd2 || bus.dur !== 6'd3) $display("FAIL t6_after_rst: got phase=%0d dur=%0d, required 2/3", bus.phase, bus.dur); else n_pass++;
    send(0, 0, 0, 1);
    do_reset();
    n_chk++; if ({bus.phase, bus.fault, bus.fault_code} !== '0)
      $display("FAIL t6_rst_fault: got phase=%0d fault=%0d code=%0d, required 0/0/0", bus.phase, bus.fault, bus.fault_code); else n_pass++;
    send(1, 0, 0, 10);
    for (int i = 0; i < 256; i++) begin
      send(0, 1, 0, 3); send(0, 0, 1, 20); send(1, 0, 0, 1);
      if (i == 254) begin
        n_chk++; if (bus.cycles !== 8'd255) $display("FAIL t6_cyc255: got %0d, required 255", bus.cycles); else n_pass++;
      end
      send(1, 0, 0, 9);
    end
    n_chk++; if (bus.cycles !== 8'd0 || bus.fault !== 1'b0 || bus.phase !== 3'd1)
      $display("FAIL t6_wrap: got cycles=%0d fault=%0d phase=%0d, required 0/0/1", bus.cycles, bus.fault, bus.phase); else n_pass++;
  endtask

  task automatic test_random();
    int  steps = 0;
    int  colour = 0;
    int  len;
    int  bad = 0;
    bit  r, y, g;
    logic [2:0] junk;
    do_reset();
    while (steps < 4000) begin
      if (m_phase == 6) begin do_reset(); colour = 0; end
      case (colour)
        0:       len = ($urandom_range(0, 3) != 0) ? 10 : $urandom_range(8, 13);
        1:       len = ($urandom_range(0, 3) != 0) ? 3 : $urandom_range(1, 4);
        default: len = ($urandom_range(0, 3) != 0) ? 20 : $urandom_range(17, 22);
      endcase
      for (int k = 0; k < len; k++) begin
        r = (colour == 0); y = (colour == 1); g = (colour == 2);
        if ($urandom_range(0, 24) == 0) begin r = 1; y = 0; g = 0; end
        if ($urandom_range(0, 149) == 0) begin junk = 3'($urandom); {r, y, g} = junk; end
        send(r, y, g, 1);
        steps++;
        n_chk++;
        if (bus.phase !== 3'(m_phase) || bus.dur !== 6'(m_dur) || bus.cycles !== 8'(m_cycles) ||
            bus.fault_code !== 3'(m_code) || bus.go !== (m_phase == 3) ||
            bus.preempt !== (m_phase == 4 || m_phase == 5) || bus.fault !== (m_phase == 6)) begin
          bad++;
          if (bad <= 10)
            $display("FAIL rand_step%0d: got phase=%0d dur=%0d cyc=%0d code=%0d, required %0d/%0d/%0d/%0d",
                     steps, bus.phase, bus.dur, bus.cycles, bus.fault_code, m_phase, m_dur, m_cycles, m_code);
        end else n_pass++;
      end
      colour = (colour + 1) % 3;
    end
  endtask

  initial begin
    bus.red = 1'b0; bus.yellow = 1'b0; bus.green = 1'b0;
    m_phase = 0; m_dur = 0; m_cycles = 0; m_code = 0;
    @(posedge clk); #1;
    test_reset();
    test_full_cycle();
    test_preempt_yellow();
    test_preempt_green_short();
    test_multi_dark();
    test_long_order();
    test_reset_midrun_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
